gravity_ctrl: RTL and testbench
===============================

GRAVITY_CTRL -- requirements
Module: gravity_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 3: number of platform lines, one bit each on lines.
REQ-002 Parameter HEIGHT_W, default 9: width of height.
REQ-003 Parameters DN_BASE=120, UP_BASE=60, PITCH=120: the contact height for line k is DN_BASE+k*PITCH when dir=0 and UP_BASE+k*PITCH when dir=1.
REQ-004 Parameters DN_MASK=3'b011, UP_MASK=3'b110, each NUM_LINES wide: line k is flippable in a direction only if its mask bit k=1.
REQ-005 Parameter BUF_CYC, default 8: press-buffer window in cycles; 0 disables buffering.
REQ-006 Parameter COOLDOWN, default 16: cycles after a flip during which requests are ignored.
REQ-007 Parameter CNT_W, default 8: width of flip_count.
REQ-008 clk  input  1  system clock; all state updates on its rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 is_dead  input  1  player dead; freezes the controller.
REQ-011 switch  input  1  gravity button, level, synchronous to clk.
REQ-012 lines  input  NUM_LINES  line k present under/over the player.
REQ-013 height  input  HEIGHT_W  player vertical position, unsigned.
REQ-014 dir  output  1  0 = normal (downward) gravity, 1 = reversed (upward) gravity.
REQ-015 flip_pulse  output  1  high for exactly one cycle, the cycle dir toggles.
REQ-016 flip_count  output  CNT_W  number of flips since reset; saturates at all-ones.
REQ-017 busy  output  1  high while in BUFFERED or COOLDOWN.

Function
REQ-018 A request is a rising edge of switch: switch=1 and its registered previous value sw_q=0; sw_q samples switch every cycle, including while is_dead=1.
REQ-019 contact=1 when, for some k, lines[k]=1, the mask bit k for the current dir is 1, and height equals that line's contact height for the current dir; contact heights are compared at HEIGHT_W bits, and out-of-range values never match.
REQ-020 FSM states: IDLE, BUFFERED, COOLDOWN.
REQ-021 IDLE, request with contact: toggle dir, pulse flip_pulse, increment flip_count, go to COOLDOWN (or stay in IDLE if COOLDOWN=0).
REQ-022 IDLE, request without contact: go to BUFFERED with the buffer counter loaded to BUF_CYC; if BUF_CYC=0, ignore the request and stay in IDLE.
REQ-023 BUFFERED, contact: flip as in REQ-021 in that same cycle, then go to COOLDOWN.
REQ-024 BUFFERED, no contact: decrement the counter; on expiry (count reaches 0 without contact) return to IDLE with no flip.
REQ-025 A new request while in BUFFERED reloads the buffer counter to BUF_CYC.
REQ-026 COOLDOWN: counter loaded to COOLDOWN on the flip and decremented each cycle; requests are ignored; enter IDLE when it reaches 0, so the first accepted request comes COOLDOWN+1 cycles after the flip.
REQ-027 Flip latency is one cycle: dir changes on the clk edge after the cycle in which the flip condition holds.
REQ-028 While is_dead=1: dir, the FSM state, both counters and flip_count hold; flip_pulse=0; requests are discarded.
REQ-029 At most one flip per cycle; a request and an expiring buffer in the same cycle resolve by REQ-025 (reload).

Reset
REQ-030 On reset=0, asynchronously: dir=0, flip_pulse=0, flip_count=0, busy=0, state=IDLE, counters=0, sw_q=1; the sw_q value makes a button held through reset produce no request.
REQ-031 A reset asserted mid-BUFFERED or mid-COOLDOWN abandons the operation with no flip and no pulse.

Structure
REQ-032 Shared package gravity_pkg holds the FSM state encoding and the default values of DN_BASE, UP_BASE and PITCH.
REQ-033 One sub-module, grav_contact (combinational contact detector per REQ-019); all other logic is in gravity_ctrl.

Verification
REQ-034 Defaults; dir=0, height=120, lines=001, switch 0->1 -> next cycle dir=1, flip_pulse=1 for one cycle, flip_count=1, busy=1.
REQ-035 Defaults; switch held high for 40 cycles at a contact -> exactly one flip; at height=180 with lines=010, a second press accepted only at or after 17 cycles later.
REQ-036 Defaults; press at height=170, dir=1, then height=180 with lines=010 five cycles later -> flip on contact; repeat with contact ten cycles later -> no flip, busy falls after 8 cycles.
REQ-037 is_dead=1 for 10 cycles with presses at a contact -> dir, flip_count and state unchanged; flip_pulse stays 0.
REQ-038 reset pulsed low during COOLDOWN with switch held high -> all outputs 0 immediately; no flip after release until switch goes 0 then 1.
REQ-039 dir=0, height=360, lines=100 (DN_MASK bit 2=0), press -> no flip; buffer expires after 8 cycles.

Source files
------------

// File: rtl/gravity_pkg.sv
// Shared definitions for the gravity-flip controller: FSM encoding and
// default contact-height geometry.
package gravity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUFFERED = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  localparam int unsigned DN_BASE_DEF = 120;
  localparam int unsigned UP_BASE_DEF = 60;
  localparam int unsigned PITCH_DEF   = 120;

endpackage

// File: rtl/grav_contact.sv
// Combinational contact detector: is the player exactly at the contact
// height of a present, flippable line for the current gravity direction?
module grav_contact
  import gravity_pkg::*;
#(
  parameter int unsigned          NUM_LINES = 3,
  parameter int unsigned          HEIGHT_W  = 9,
  parameter int unsigned          DN_BASE   = DN_BASE_DEF,
  parameter int unsigned          UP_BASE   = UP_BASE_DEF,
  parameter int unsigned          PITCH     = PITCH_DEF,
  parameter logic [NUM_LINES-1:0] DN_MASK   = 3'b011,
  parameter logic [NUM_LINES-1:0] UP_MASK   = 3'b110
) (
  input  logic                 dir,
  input  logic [NUM_LINES-1:0] lines,
  input  logic [HEIGHT_W-1:0]  height,
  output logic                 contact_c
);

  logic [NUM_LINES-1:0] hit;

  // Heights are compared zero-extended, so a contact height beyond the
  // height range can never match.
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    localparam int unsigned DN_H = DN_BASE + 32'(k) * PITCH;
    localparam int unsigned UP_H = UP_BASE + 32'(k) * PITCH;
    assign hit[k] = lines[k] & (dir ? (UP_MASK[k] & (32'(height) == UP_H))
                                    : (DN_MASK[k] & (32'(height) == DN_H)));
  end

  assign contact_c = |hit;

endmodule

// File: rtl/gravity_ctrl.sv
// Gravity-flip controller: button edge detection, press buffering until
// contact, post-flip cooldown, flip counting and freeze while dead.
module gravity_ctrl
  import gravity_pkg::*;
#(
  parameter int unsigned          NUM_LINES = 3,
  parameter int unsigned          HEIGHT_W  = 9,
  parameter int unsigned          DN_BASE   = DN_BASE_DEF,
  parameter int unsigned          UP_BASE   = UP_BASE_DEF,
  parameter int unsigned          PITCH     = PITCH_DEF,
  parameter logic [NUM_LINES-1:0] DN_MASK   = 3'b011,
  parameter logic [NUM_LINES-1:0] UP_MASK   = 3'b110,
  parameter int unsigned          BUF_CYC   = 8,
  parameter int unsigned          COOLDOWN  = 16,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_dead,
  input  logic                 switch,
  input  logic [NUM_LINES-1:0] lines,
  input  logic [HEIGHT_W-1:0]  height,
  output logic                 dir,
  output logic                 flip_pulse,
  output logic [CNT_W-1:0]     flip_count,
  output logic                 busy
);

  localparam int unsigned TMR_MAX = (BUF_CYC > COOLDOWN) ? BUF_CYC : COOLDOWN;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               sw_q;
  logic               dir_q, dir_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               contact_c;
  logic               req_c;
  logic               flip_c;

  grav_contact #(
    .NUM_LINES (NUM_LINES),
    .HEIGHT_W  (HEIGHT_W),
    .DN_BASE   (DN_BASE),
    .UP_BASE   (UP_BASE),
    .PITCH     (PITCH),
    .DN_MASK   (DN_MASK),
    .UP_MASK   (UP_MASK)
  ) u_contact (
    .dir       (dir_q),
    .lines     (lines),
    .height    (height),
    .contact_c (contact_c)
  );

  assign req_c = switch & ~sw_q;

  // Next-state and output logic; everything holds while the player is dead.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    flip_c  = 1'b0;

    if (!is_dead) begin
      case (state_q)
        ST_IDLE: begin
          if (req_c) begin
            if (contact_c) begin
              flip_c = 1'b1;
            end else if (BUF_CYC != 0) begin
              state_d = ST_BUFFERED;
              tmr_d   = TMR_W'(BUF_CYC);
            end
          end
        end
        ST_BUFFERED: begin
          if (contact_c) begin
            flip_c = 1'b1;
          end else if (req_c) begin
            tmr_d = TMR_W'(BUF_CYC);
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q <= TMR_W'(1)) state_d = ST_IDLE;
          end
        end
        ST_COOLDOWN: begin
          tmr_d = tmr_q - TMR_W'(1);
          if (tmr_q <= TMR_W'(1)) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase

      if (flip_c) begin
        dir_d   = ~dir_q;
        pulse_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (COOLDOWN != 0) begin
          state_d = ST_COOLDOWN;
          tmr_d   = TMR_W'(COOLDOWN);
        end else begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // sw_q resets high so a button held through reset is not a request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      sw_q    <= 1'b1;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sw_q    <= switch;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign dir        = dir_q;
  assign flip_pulse = pulse_q;
  assign flip_count = cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gravity_ctrl.sv
// Scoreboard bench for gravity_ctrl: a deadline-based reference model
// predicts outputs per cycle; a monitor compares them after each edge.
module tb_gravity_ctrl;

  localparam int BUF_CYC  = 8;
  localparam int COOLDOWN = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       is_dead;
  logic       switch;
  logic [2:0] lines;
  logic [8:0] height;
  logic       dir;
  logic       flip_pulse;
  logic [7:0] flip_count;
  logic       busy;

  gravity_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .is_dead    (is_dead),
    .switch     (switch),
    .lines      (lines),
    .height     (height),
    .dir        (dir),
    .flip_pulse (flip_pulse),
    .flip_count (flip_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit dir;
    bit pulse;
    int cnt;
    bit busy;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: absolute-cycle deadlines rather than down-counters.
  int  cyc = 0;
  bit  m_dir;
  int  m_count;
  bit  m_prev_sw;
  int  cool_end;
  bit  buf_on;
  int  buf_end;

  task automatic chk(string name, int act, int exp, int at);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, at, act, exp);
    end
  endtask

  function automatic bit m_contact(bit d, logic [2:0] ln, int h);
    int base;
    logic [2:0] mask;
    base = d ? 60 : 120;
    mask = d ? 3'b110 : 3'b011;
    for (int k = 0; k < 3; k++)
      if (ln[k] && mask[k] && h == base + k * 120) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_dir     = 1'b0;
    m_count   = 0;
    m_prev_sw = 1'b1;
    cool_end  = -1;
    buf_on    = 1'b0;
    buf_end   = -1;
  endtask

  task automatic model_step(bit sw, logic [2:0] ln, int h, bit dead);
    bit   req, flip, in_cool, in_buf, pulse, con;
    exp_t e;
    req       = sw && !m_prev_sw;
    m_prev_sw = sw;
    flip      = 1'b0;
    con       = m_contact(m_dir, ln, h);
    in_cool   = (cyc <= cool_end);
    in_buf    = buf_on && (cyc <= buf_end);
    if (!in_buf) buf_on = 1'b0;
    if (dead) begin
      if (in_cool) cool_end++;
      if (in_buf) buf_end++;
    end else if (in_cool) begin
      flip = 1'b0;
    end else if (in_buf) begin
      if (con) flip = 1'b1;
      else if (req) buf_end = cyc + BUF_CYC;
    end else if (req) begin
      if (con) flip = 1'b1;
      else begin
        buf_on  = 1'b1;
        buf_end = cyc + BUF_CYC;
      end
    end
    pulse = flip;
    if (flip) begin
      m_dir = !m_dir;
      if (m_count < 255) m_count++;
      cool_end = cyc + COOLDOWN;
      buf_on   = 1'b0;
    end
    e.dir   = m_dir;
    e.pulse = pulse;
    e.cnt   = m_count;
    e.busy  = (cyc + 1 <= cool_end) || (buf_on && cyc + 1 <= buf_end);
    e.cyc   = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  // Called at a negedge: drive one cycle of inputs and predict its outcome.
  task automatic step(bit sw, logic [2:0] ln, logic [8:0] h, bit dead);
    switch  = sw;
    lines   = ln;
    height  = h;
    is_dead = dead;
    model_step(sw, ln, int'(h), dead);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("reset_dir",   int'(dir),        0, cyc);
    chk("reset_pulse", int'(flip_pulse), 0, cyc);
    chk("reset_count", int'(flip_count), 0, cyc);
    chk("reset_busy",  int'(busy),       0, cyc);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dir",        int'(dir),        int'(e.dir),   e.cyc);
        chk("flip_pulse", int'(flip_pulse), int'(e.pulse), e.cyc);
        chk("flip_count", int'(flip_count), e.cnt,         e.cyc);
        chk("busy",       int'(busy),       int'(e.busy),  e.cyc);
      end
    end
  end

  initial begin : stimulus
    int hs[8];
    hs = '{60, 120, 170, 180, 240, 300, 360, 0};
    reset   = 1'b1;
    is_dead = 1'b0;
    switch  = 1'b0;
    lines   = 3'b000;
    height  = 9'd0;
    #2;
    do_reset();

    // Basic flip, then held button and repeated presses against cooldown
    step(0, 3'b001, 120, 0);
    step(0, 3'b001, 120, 0);
    repeat (40) step(1, 3'b001, 120, 0);
    step(0, 3'b010, 180, 0);
    for (int i = 0; i < 24; i++) step(i[0], 3'b010, 180, 0);

    // Buffered press landing on contact, then one that expires
    do_reset();
    step(0, 3'b001, 120, 0);
    step(1, 3'b001, 120, 0);
    repeat (20) step(0, 3'b001, 120, 0);
    step(1, 3'b000, 170, 0);
    repeat (4) step(0, 3'b000, 170, 0);
    step(0, 3'b010, 180, 0);
    repeat (20) step(0, 3'b000, 170, 0);
    step(1, 3'b000, 170, 0);
    repeat (9) step(0, 3'b000, 170, 0);
    step(0, 3'b010, 180, 0);
    repeat (4) step(0, 3'b000, 170, 0);

    // Dead player freezes everything
    do_reset();
    for (int i = 0; i < 10; i++) step(i[0], 3'b001, 120, 1);
    repeat (3) step(0, 3'b001, 120, 0);
    step(1, 3'b000, 170, 0);
    repeat (3) step(0, 3'b000, 170, 1);
    repeat (10) step(0, 3'b000, 170, 0);

    // Reset during cooldown with the button held
    do_reset();
    step(0, 3'b001, 120, 0);
    step(1, 3'b001, 120, 0);
    repeat (5) step(1, 3'b001, 120, 0);
    do_reset();
    repeat (5) step(1, 3'b001, 120, 0);
    step(0, 3'b001, 120, 0);
    step(1, 3'b001, 120, 0);
    repeat (3) step(0, 3'b001, 120, 0);

    // Masked-off line never matches; buffer expires
    do_reset();
    step(0, 3'b100, 360, 0);
    step(1, 3'b100, 360, 0);
    repeat (12) step(0, 3'b100, 360, 0);

    // Flip counter saturation
    do_reset();
    for (int i = 0; i < 5200; i++) begin
      if (m_dir) step(i[0], 3'b010, 180, 0);
      else       step(i[0], 3'b001, 120, 0);
    end
    repeat (3) step(0, 3'b000, 0, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int idx;
      logic [8:0] h;
      idx = int'($urandom_range(0, 7));
      h   = (idx == 7) ? 9'($urandom_range(0, 511)) : 9'(hs[idx]);
      step(1'($urandom_range(0, 2) == 0), 3'($urandom), h,
           1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
